pixel_readout_scheduler: RTL and testbench

//  Frame sequencer for the pixel sensor datapath. Drives pixel reset, exposure, ADC ramp

---
 rtl/pixel_readout_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pixel_readout_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_scheduler.sv
// Frame sequencer: pixel reset, exposure, ADC ramp conversion, then row/column readout.
// Define CONTINUOUS_CAPTURE_EN to chain frames back to back without a new START.
module pixel_readout_scheduler #(
    parameter int PIXEL_ARRAY_HEIGHT = 128,
    parameter int PIXEL_ARRAY_WIDTH  = 128,
    parameter int OUTPUT_BUS_WIDTH   = 4,
    parameter int PIXEL_BITS         = 8,
    parameter int RESET_CYCLES       = 4,
    parameter int EXP_W              = 16,
    localparam int WPR   = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
    localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [EXP_W-1:0]      EXPOSURE_CYCLES,
    output logic                  PIXEL_RESET,
    output logic                  PIXEL_EXPOSE,
    output logic                  ADC_ENABLE,
    output logic [PIXEL_BITS-1:0] ADC_RAMP,
    output logic [ROW_W-1:0]      ROW_SEL,
    output logic [COL_W-1:0]      COL_SEL,
    output logic                  READ_VALID,
    input  logic                  BUF_READY,
    output logic                  NEW_ROW,
    output logic                  FRAME_FINISHED,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        RST_PIX,
        EXPOSE,
        CONVERT,
        READ,
        DONE
    } state_t;

    localparam logic [EXP_W-1:0]      RST_LAST = EXP_W'(RESET_CYCLES - 1);
    localparam logic [PIXEL_BITS-1:0] RAMP_MAX = {PIXEL_BITS{1'b1}};
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(WPR - 1);

    state_t                state_q, state_d;
    logic [EXP_W-1:0]      cnt_q, cnt_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    logic [PIXEL_BITS-1:0] ramp_q, ramp_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  armed_q, armed_d;
    logic                  pixel_reset_q, pixel_expose_q, adc_enable_q;
    logic                  read_valid_q, frame_finished_q, busy_q;
    logic [EXP_W-1:0]      exp_latch;

    // A zero exposure request still opens the window for one cycle.
    assign exp_latch = (EXPOSURE_CYCLES == '0) ? EXP_W'(1) : EXPOSURE_CYCLES;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        ramp_d  = ramp_q;
        row_d   = row_q;
        col_d   = col_q;
        armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                // armed_q blocks a START seen on the first edge after reset release.
                if (START && armed_q) begin
                    state_d = RST_PIX;
                    cnt_d   = '0;
                    exp_d   = exp_latch;
                end
            end
            RST_PIX: begin
                if (cnt_q == RST_LAST) begin
                    state_d = EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + EXP_W'(1);
                end
            end
            EXPOSE: begin
                if (cnt_q == exp_q - EXP_W'(1)) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + EXP_W'(1);
                end
            end
            CONVERT: begin
                if (ramp_q == RAMP_MAX) begin
                    state_d = READ;
                    ramp_d  = '0;
                end else begin
                    ramp_d = ramp_q + PIXEL_BITS'(1);
                end
            end
            READ: begin
                if (BUF_READY) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE: begin
`ifdef CONTINUOUS_CAPTURE_EN
                state_d = RST_PIX;
                cnt_d   = '0;
                exp_d   = exp_latch;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every transition and clears the datapath counters.
        if (ABORT && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            ramp_d  = '0;
            row_d   = '0;
            col_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            exp_q            <= '0;
            ramp_q           <= '0;
            row_q            <= '0;
            col_q            <= '0;
            armed_q          <= 1'b0;
            pixel_reset_q    <= 1'b0;
            pixel_expose_q   <= 1'b0;
            adc_enable_q     <= 1'b0;
            read_valid_q     <= 1'b0;
            frame_finished_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            exp_q            <= exp_d;
            ramp_q           <= ramp_d;
            row_q            <= row_d;
            col_q            <= col_d;
            armed_q          <= armed_d;
            pixel_reset_q    <= (state_d == RST_PIX);
            pixel_expose_q   <= (state_d == EXPOSE);
            adc_enable_q     <= (state_d == CONVERT);
            read_valid_q     <= (state_d == READ);
            frame_finished_q <= (state_d == DONE);
            busy_q           <= (state_d != IDLE);
        end
    end

    assign PIXEL_RESET    = pixel_reset_q;
    assign PIXEL_EXPOSE   = pixel_expose_q;
    assign ADC_ENABLE     = adc_enable_q;
    assign ADC_RAMP       = ramp_q;
    assign ROW_SEL        = row_q;
    assign COL_SEL        = col_q;
    assign READ_VALID     = read_valid_q;
    assign FRAME_FINISHED = frame_finished_q;
    assign BUSY           = busy_q;
    assign NEW_ROW        = read_valid_q & (col_q == '0);

endmodule

// File: tb/tb_pixel_readout_scheduler.sv
// Directed self-checking bench for pixel_readout_scheduler (4x8 array, 4-pixel bus, 4-bit ADC).
// Cycle k counts negedges after START is driven; k=1 is the first RST_PIX cycle.
module tb_pixel_readout_scheduler;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [15:0] EXPOSURE_CYCLES = 16'd0;
    logic        BUF_READY = 1'b1;
    logic        PIXEL_RESET, PIXEL_EXPOSE, ADC_ENABLE, READ_VALID;
    logic        NEW_ROW, FRAME_FINISHED, BUSY;
    logic [3:0]  ADC_RAMP;
    logic [1:0]  ROW_SEL;
    logic [0:0]  COL_SEL;

    int checks = 0;
    int errors = 0;

    pixel_readout_scheduler #(
        .PIXEL_ARRAY_HEIGHT(4),
        .PIXEL_ARRAY_WIDTH (8),
        .OUTPUT_BUS_WIDTH  (4),
        .PIXEL_BITS        (4),
        .RESET_CYCLES      (4),
        .EXP_W             (16)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .START          (START),
        .ABORT          (ABORT),
        .EXPOSURE_CYCLES(EXPOSURE_CYCLES),
        .PIXEL_RESET    (PIXEL_RESET),
        .PIXEL_EXPOSE   (PIXEL_EXPOSE),
        .ADC_ENABLE     (ADC_ENABLE),
        .ADC_RAMP       (ADC_RAMP),
        .ROW_SEL        (ROW_SEL),
        .COL_SEL        (COL_SEL),
        .READ_VALID     (READ_VALID),
        .BUF_READY      (BUF_READY),
        .NEW_ROW        (NEW_ROW),
        .FRAME_FINISHED (FRAME_FINISHED),
        .BUSY           (BUSY)
    );

    always #5 CLK = ~CLK;

    // Order: PIXEL_RESET, PIXEL_EXPOSE, ADC_ENABLE, READ_VALID, NEW_ROW, FRAME_FINISHED, BUSY
    function automatic logic [6:0] flags();
        return {PIXEL_RESET, PIXEL_EXPOSE, ADC_ENABLE, READ_VALID, NEW_ROW, FRAME_FINISHED, BUSY};
    endfunction

    task automatic test_reset();
        RESET = 1'b0;
        #1;
        checks++;
        if ({flags(), ADC_RAMP, ROW_SEL, COL_SEL} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b, expected all zero", {flags(), ADC_RAMP, ROW_SEL, COL_SEL});
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_full_frame();
        logic [6:0] exp_f;
        logic [3:0] e_ramp;
        logic [1:0] e_row;
        logic [0:0] e_col;
        logic       e_rv;
        int         idx;
        int         new_rows = 0;
        EXPOSURE_CYCLES = 16'd10;
        START = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            START = 1'b0;
            e_rv   = (k >= 31 && k <= 38);
            idx    = k - 31;
            e_row  = e_rv ? 2'(idx / 2) : 2'd0;
            e_col  = e_rv ? 1'(idx % 2) : 1'b0;
            e_ramp = (k >= 15 && k <= 30) ? 4'(k - 15) : 4'd0;
            exp_f  = {(k >= 1 && k <= 4), (k >= 5 && k <= 14), (k >= 15 && k <= 30), e_rv,
                      e_rv && (e_col == 1'b0), (k == 39), (k <= 39)};
            if (NEW_ROW === 1'b1) new_rows++;
            checks++;
            if (flags() !== exp_f) begin
                errors++;
                $display("[TB] FAIL full_frame_flags k=%0d: got %b, expected %b", k, flags(), exp_f);
            end
            checks++;
            if ({ADC_RAMP, ROW_SEL, COL_SEL} !== {e_ramp, e_row, e_col}) begin
                errors++;
                $display("[TB] FAIL full_frame_addr k=%0d: got ramp=%0d row=%0d col=%0d, expected ramp=%0d row=%0d col=%0d",
                         k, ADC_RAMP, ROW_SEL, COL_SEL, e_ramp, e_row, e_col);
            end
        end
        checks++;
        if (new_rows != 4) begin
            errors++;
            $display("[TB] FAIL new_row_count: got %0d, expected 4", new_rows);
        end
    endtask

    task automatic test_stall();
        int idx;
        EXPOSURE_CYCLES = 16'd3;
        START = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            @(negedge CLK);
            START = 1'b0;
            if (k >= 24 && k <= 36) begin
                idx = (k < 29) ? k - 24 : (k <= 34) ? 5 : k - 29;
                checks++;
                if ({READ_VALID, ROW_SEL, COL_SEL} !== {1'b1, 2'(idx / 2), 1'(idx % 2)}) begin
                    errors++;
                    $display("[TB] FAIL stall_word k=%0d: got valid=%b row=%0d col=%0d, expected valid=1 row=%0d col=%0d",
                             k, READ_VALID, ROW_SEL, COL_SEL, idx / 2, idx % 2);
                end
            end
            if (k >= 23) begin
                checks++;
                if (FRAME_FINISHED !== (k == 37)) begin
                    errors++;
                    $display("[TB] FAIL stall_finish k=%0d: got %b, expected %b", k, FRAME_FINISHED, (k == 37));
                end
            end
            BUF_READY = !(k >= 29 && k <= 33);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_idle: got BUSY=%b, expected 0", BUSY);
        end
        BUF_READY = 1'b1;
    endtask

    task automatic test_zero_exposure();
        int expose_cycles = 0;
        EXPOSURE_CYCLES = 16'd0;
        START = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge CLK);
            START = (k == 3 || k == 10);
            if (PIXEL_EXPOSE === 1'b1) expose_cycles++;
            if (k == 5 || k == 6) begin
                checks++;
                if ({PIXEL_EXPOSE, ADC_ENABLE, ADC_RAMP} !== {(k == 5), (k == 6), 4'd0}) begin
                    errors++;
                    $display("[TB] FAIL zero_exp_phase k=%0d: got expose=%b adc=%b ramp=%0d, expected expose=%b adc=%b ramp=0",
                             k, PIXEL_EXPOSE, ADC_ENABLE, ADC_RAMP, (k == 5), (k == 6));
                end
            end
            checks++;
            if ({FRAME_FINISHED, BUSY} !== {(k == 30), (k <= 30)}) begin
                errors++;
                $display("[TB] FAIL zero_exp_timing k=%0d: got ff=%b busy=%b, expected ff=%b busy=%b",
                         k, FRAME_FINISHED, BUSY, (k == 30), (k <= 30));
            end
        end
        START = 1'b0;
        checks++;
        if (expose_cycles != 1) begin
            errors++;
            $display("[TB] FAIL zero_exp_width: got %0d cycles, expected 1", expose_cycles);
        end
    endtask

    task automatic test_abort();
        EXPOSURE_CYCLES = 16'd2;
        START = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge CLK);
            START = 1'b0;
            ABORT = 1'b0;
            if (k == 25) begin
                checks++;
                if ({READ_VALID, NEW_ROW, ROW_SEL, COL_SEL} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL abort_target: got valid=%b newrow=%b row=%0d col=%0d, expected 1 1 1 0",
                             READ_VALID, NEW_ROW, ROW_SEL, COL_SEL);
                end
                ABORT = 1'b1;
            end
            if (k >= 26) begin
                checks++;
                if ({flags(), ROW_SEL, COL_SEL} !== 10'd0) begin
                    errors++;
                    $display("[TB] FAIL abort_idle k=%0d: got %b, expected all zero", k, {flags(), ROW_SEL, COL_SEL});
                end
            end
        end
        START = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            START = 1'b0;
            checks++;
            if ({FRAME_FINISHED, BUSY} !== {(k == 31), (k <= 31)}) begin
                errors++;
                $display("[TB] FAIL abort_restart k=%0d: got ff=%b busy=%b, expected ff=%b busy=%b",
                         k, FRAME_FINISHED, BUSY, (k == 31), (k <= 31));
            end
        end
    endtask

    task automatic test_reset_mid_convert();
        EXPOSURE_CYCLES = 16'd1;
        START = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        checks++;
        if ({ADC_ENABLE, ADC_RAMP} !== {1'b1, 4'd4}) begin
            errors++;
            $display("[TB] FAIL convert_before_reset: got adc=%b ramp=%0d, expected adc=1 ramp=4", ADC_ENABLE, ADC_RAMP);
        end
        #2 RESET = 1'b0;
        #1;
        checks++;
        if ({flags(), ADC_RAMP, ROW_SEL, COL_SEL} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b, expected all zero", {flags(), ADC_RAMP, ROW_SEL, COL_SEL});
        end
        @(negedge CLK);
        RESET = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({PIXEL_RESET, BUSY} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL start_at_release k=%0d: got reset=%b busy=%b, expected 0 0", k, PIXEL_RESET, BUSY);
            end
            @(negedge CLK);
        end
    endtask

`ifdef CONTINUOUS_CAPTURE_EN
    task automatic test_continuous();
        int finishes = 0;
        EXPOSURE_CYCLES = 16'd1;
        START = 1'b1;
        for (int k = 1; k <= 96; k++) begin
            @(negedge CLK);
            START = 1'b0;
            ABORT = (k == 95);
            if (FRAME_FINISHED === 1'b1) finishes++;
            if (k <= 94) begin
                checks++;
                if ({FRAME_FINISHED, PIXEL_RESET, BUSY} !== {(k % 30 == 0), (k % 30 >= 1 && k % 30 <= 4), 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL continuous k=%0d: got ff=%b reset=%b busy=%b", k, FRAME_FINISHED, PIXEL_RESET, BUSY);
                end
            end
        end
        ABORT = 1'b0;
        checks++;
        if ({finishes, BUSY} !== {32'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL continuous_stop: got finishes=%0d busy=%b, expected 3 0", finishes, BUSY);
        end
    endtask
`else
    task automatic test_single_shot();
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++;
            if ({PIXEL_RESET, BUSY} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL single_shot k=%0d: got reset=%b busy=%b, expected 0 0", k, PIXEL_RESET, BUSY);
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] starting pixel_readout_scheduler bench");
        test_reset();
        test_full_frame();
        test_stall();
        test_zero_exposure();
        test_abort();
        test_reset_mid_convert();
`ifdef CONTINUOUS_CAPTURE_EN
        test_continuous();
`else
        test_single_shot();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
